// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports
// (B has priority over A on the same address), optional same-cycle bypass,
// hardwired-zero r0, SP preset, and a one-entry-per-cycle clear sequencer.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int SP_IDX   = 29,
    parameter int SP_INIT  = 128,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wa_en_i,
    input  logic [ADDR_W-1:0]        wa_addr_i,
    input  logic [DATA_W-1:0]        wa_data_i,
    input  logic                     wb_en_i,
    input  logic [ADDR_W-1:0]        wb_addr_i,
    input  logic [DATA_W-1:0]        wb_data_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_L    = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_INIT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                clearing;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem;

    assign clearing   = (state_q == S_CLEAR);
    assign clr_busy_o = (state_q == S_CLEAR);
    assign clr_done_o = (state_q == S_DONE);

    // Clear sequencer state and index registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Clear sequencer next state: walk every entry once, then pulse done
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Storage: one register per implemented entry; addresses beyond
    // NUM_REGS never match any entry, so such writes fall away naturally.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [ADDR_W-1:0] R_ADDR = ADDR_W'(r);
        localparam logic [DATA_W-1:0] R_INIT = (r == SP_IDX) ? SP_VAL : '0;
        localparam bit                R_WR   = !((ZERO_REG != 0) && (r == 0));

        logic [DATA_W-1:0] q_q, q_d;
        logic              we;

        // Entry update: clear overrides ports; B beats A on the same address
        always_comb begin
            we  = 1'b0;
            q_d = q_q;
            if (clearing) begin
                if (idx_q == R_ADDR) begin
                    we  = 1'b1;
                    q_d = R_INIT;
                end
            end else if (R_WR) begin
                if (wb_en_i && (wb_addr_i == R_ADDR)) begin
                    we  = 1'b1;
                    q_d = wb_data_i;
                end else if (wa_en_i && (wa_addr_i == R_ADDR)) begin
                    we  = 1'b1;
                    q_d = wa_data_i;
                end
            end
        end

        // Entry register with its own reset value
        always_ff @(posedge clk_i or negedge rst_n) begin
            if (!rst_n)  q_q <= R_INIT;
            else if (we) q_q <= q_d;
        end

        assign mem[r] = q_q;
    end

    // Read ports, each independent; bypass is suppressed while clearing
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

        // Read mux: range/zero check, then bypass, then stored value
        always_comb begin
            rd = '0;
            if (({1'b0, ra} < NUM_L) && !((ZERO_REG != 0) && (ra == '0))) begin
                rd = mem[ra];
                if ((BYPASS != 0) && !clearing) begin
                    if (wb_en_i && (wb_addr_i == ra))      rd = wb_data_i;
                    else if (wa_en_i && (wa_addr_i == ra)) rd = wa_data_i;
                end
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass on / off) share stimulus,
// a behavioural model is compared on every falling edge, plus directed
// literal checks for the documented scenarios.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rdata, rdata_nb;
    logic        wa_en = 0, wb_en = 0, clr_req = 0;
    logic [4:0]  wa_addr = '0, wb_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic        busy, done, busy_nb, done_nb;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) u_dut (
        .clk_i(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdata),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .clr_req_i(clr_req), .clr_busy_o(busy), .clr_done_o(done)
    );

    reg_file_mp #(.BYPASS(0)) u_nb (
        .clk_i(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rdata_nb),
        .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .clr_req_i(clr_req), .clr_busy_o(busy_nb), .clr_done_o(done_nb)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] mem [32];
    bit          m_clr, m_done;
    int          m_idx;

    function automatic logic [31:0] init_val(int i);
        return (i == 29) ? 32'd128 : 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            m_clr  <= 0;
            m_idx  <= 0;
            m_done <= 0;
        end else if (m_clr) begin
            mem[m_idx] <= init_val(m_idx);
            if (m_idx == 31) begin
                m_clr  <= 0;
                m_done <= 1;
            end else begin
                m_idx <= m_idx + 1;
            end
        end else begin
            m_done <= 0;
            if (wa_en && wa_addr != 0) mem[wa_addr] <= wa_data;
            if (wb_en && wb_addr != 0) mem[wb_addr] <= wb_data;
            if (!m_done && clr_req) begin
                m_clr <= 1;
                m_idx <= 0;
            end
        end
    end

    function automatic logic [31:0] m_read(logic [4:0] a, bit byp);
        if (a == 0) return 32'd0;
        if (byp && !m_clr) begin
            if (wb_en && wb_addr == a) return wb_data;
            if (wa_en && wa_addr == a) return wa_data;
        end
        return mem[a];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle against the model; also count busy/done cycles
    int busy_cyc = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_rd%0d", k), rdata[k*32 +: 32],
                m_read(rd_addr[k*5 +: 5], 1'b1));
            chk($sformatf("model_nb_rd%0d", k), rdata_nb[k*32 +: 32],
                m_read(rd_addr[k*5 +: 5], 1'b0));
        end
        chk("model_busy", {31'd0, busy}, {31'd0, m_clr});
        chk("model_done", {31'd0, done}, {31'd0, m_done});
        chk("model_nb_busy", {31'd0, busy_nb}, {31'd0, m_clr});
        if (busy) busy_cyc++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n, b0, d0;
        #1 rst_n = 1'b0;
        #11 rst_n = 1'b1;

        // 1: reset contents
        rd_addr = {5'd5, 5'd29};
        #1;
        chk("rst_r29", rdata[31:0], 32'd128);
        chk("rst_r5", rdata[63:32], 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        step();

        // 2: bypass vs stored
        wa_en = 1; wa_addr = 5'd7; wa_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd7};
        #2;
        chk("byp_same_cycle", rdata[31:0], 32'hDEADBEEF);
        chk("nobyp_same_cycle", rdata_nb[31:0], 32'h0);
        step();
        wa_en = 0;
        #2;
        chk("byp_stored", rdata[31:0], 32'hDEADBEEF);
        chk("nobyp_stored", rdata_nb[31:0], 32'hDEADBEEF);
        step();

        // 3: A/B collision, zero register
        wa_en = 1; wa_addr = 5'd3; wa_data = 32'h11;
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h22;
        rd_addr = {5'd0, 5'd3};
        #2 chk("collide_byp", rdata[31:0], 32'h22);
        step();
        wb_en = 0; wa_addr = 5'd0; wa_data = 32'h55;
        #2 chk("collide_stored", rdata_nb[31:0], 32'h22);
        step();
        wa_en = 0;
        rd_addr = {5'd3, 5'd0};
        #2 chk("r0_zero", rdata[31:0], 32'h0);
        step();

        // 4: fill, then clear
        for (int i = 1; i < 32; i++) begin
            wa_en = 1; wa_addr = 5'(i); wa_data = 32'(i * 3);
            step();
        end
        wa_en = 0;
        rd_addr = {5'd10, 5'd30};
        #2;
        chk("fill_r30", rdata[31:0], 32'd90);
        chk("fill_r10", rdata[63:32], 32'd30);
        step();
        b0 = busy_cyc; d0 = done_cnt;
        clr_req = 1;
        step();
        clr_req = 0;
        wa_en = 1; wa_addr = 5'd10; wa_data = 32'hABC;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        wa_en = 0;
        if (n >= 40) chk("clr_timeout", 32'(n), 32'd32);
        step(); step();
        chk("clr_busy_cycles", 32'(busy_cyc - b0), 32'd32);
        chk("clr_done_pulses", 32'(done_cnt - d0), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'd0, 5'(i)};
            #2 chk($sformatf("clr_r%0d", i), rdata[31:0], init_val(i));
            step();
        end

        // 5: reset in the middle of a clear
        wa_en = 1; wa_addr = 5'd5; wa_data = 32'h5A;
        step();
        wa_addr = 5'd29; wa_data = 32'h7;
        step();
        wa_en = 0;
        d0 = done_cnt;
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (4) step();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_async", {31'd0, busy}, 32'd0);
        chk("mid_done_async", {31'd0, done}, 32'd0);
        step();
        #2 rst_n = 1'b1;
        rd_addr = {5'd5, 5'd29};
        #1;
        chk("mid_r29", rdata[31:0], 32'd128);
        chk("mid_r5", rdata[63:32], 32'd0);
        repeat (3) step();
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);

        // new clear completes normally
        b0 = busy_cyc; d0 = done_cnt;
        clr_req = 1;
        step();
        clr_req = 0;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) chk("clr2_timeout", 32'(n), 32'd32);
        step(); step();
        chk("clr2_busy_cycles", 32'(busy_cyc - b0), 32'd32);
        chk("clr2_done_pulses", 32'(done_cnt - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
